usb_dev_enum_resp: RTL and testbench
====================================

USB_DEV_ENUM_RESP -- requirements
Module: usb_dev_enum_resp

Interface
REQ-001 SHALL have the following ports.
- c, input, 1: bus clock, 100 MHz.
- rst, input, 1: reset, synchronous, active-low.
- bus_rst, input, 1: USB bus reset detected by the line receiver; one-cycle pulse.
- tok_dv, input, 1: one-cycle strobe; a CRC-checked token is valid.
- tok_pid, input, 4: token PID.
- tok_addr, input, 7: token address field.
- tok_ep, input, 4: token endpoint field.
- rxd, input, 8: received data byte (PID stripped, CRC16 bytes included).
- rxdv, input, 1: rxd valid.
- rx_eop, input, 1: one-cycle strobe; data packet ended.
- rx_crc_ok, input, 1: CRC16 good; sampled only with rx_eop.
- tx_sie_done, input, 1: one-cycle strobe; the requested transmission has finished.
- hs_start, output, 1: one-cycle strobe; send the handshake on hs_pid.
- hs_pid, output, 4: handshake PID (ACK, NAK or STALL).
- zlp_start, output, 1: one-cycle strobe; send a zero-length DATA1 packet.
- dev_addr, output, 7: current device address.
- configured, output, 1: configuration value is non-zero.
- config_value, output, 8: last accepted bConfigurationValue.

Function
REQ-002 A token SHALL match only when tok_addr==dev_addr and tok_ep==0; all other tokens are ignored.
REQ-003 States SHALL be IDLE, SETUP_DATA, SETUP_HS, STATUS_WAIT, STATUS_TX, STATUS_ACK and APPLY.
REQ-004 From IDLE, a matching SETUP token (PID 4'hD) SHALL go to SETUP_DATA and clear the byte counter.
REQ-005 SETUP_DATA SHALL store bytes 0-7 in an 8-byte buffer and count all bytes, saturating at 15.
REQ-006 On rx_eop, the packet SHALL be accepted only if the count is exactly 10 and rx_crc_ok=1; otherwise return to IDLE with no handshake.
REQ-007 An accepted packet SHALL go to SETUP_HS and pulse hs_start once.
- hs_pid=ACK (4'h2) for SET_ADDRESS: byte0=8'h00, byte1=8'h05.
- hs_pid=ACK for SET_CONFIGURATION: byte0=8'h00, byte1=8'h09.
- hs_pid=STALL (4'hE) for any other request.
REQ-008 After tx_sie_done, a STALLed request SHALL return to IDLE; an ACKed request SHALL go to STATUS_WAIT.
REQ-009 In STATUS_WAIT, a matching IN token (4'h9) SHALL go to STATUS_TX and pulse zlp_start once.
REQ-010 After tx_sie_done in STATUS_TX, the block SHALL go to STATUS_ACK.
REQ-011 In STATUS_ACK, only a host ACK SHALL go to APPLY. The host ACK is tok_dv with tok_pid=4'h2, with address and endpoint ignored.
REQ-012 In STATUS_ACK, any other tok_dv SHALL return to STATUS_WAIT so the status stage is retried.
REQ-013 APPLY SHALL last exactly one cycle and update state as follows, then go to IDLE.
- SET_ADDRESS: dev_addr <= byte2[6:0].
- SET_CONFIGURATION: config_value <= byte2; configured <= (byte2!=0).
REQ-014 dev_addr SHALL NOT change before APPLY, so the status IN is still addressed to the old address.
REQ-015 A matching IN token in IDLE SHALL pulse hs_start with hs_pid=STALL.
REQ-016 A matching SETUP token in any state other than SETUP_HS and STATUS_TX SHALL abort the current transfer, discard any pending APPLY and restart SETUP_DATA. SETUP tokens in SETUP_HS and STATUS_TX are ignored.
REQ-017 bus_rst SHALL have priority over all other events in the same cycle.
- It forces the state to IDLE.
- It sets dev_addr=0, config_value=0 and configured=0.
REQ-018 hs_start and zlp_start SHALL never be asserted in the same cycle.
REQ-019 Each start strobe SHALL be asserted for exactly one cycle per transaction.
REQ-020 Latency from the triggering strobe (rx_eop or tok_dv) to hs_start/zlp_start SHALL be exactly 1 cycle.

Reset
REQ-021 While rst=0 at a rising edge of c, the block SHALL hold the following values.
- State: IDLE.
- dev_addr=0, config_value=0, configured=0.
- hs_start=0, zlp_start=0, hs_pid=0.
- Byte counter and setup buffer cleared.
REQ-022 Reset asserted mid-transfer SHALL discard the transfer with no further strobes.

Structure
REQ-023 PID codes (SETUP, IN, ACK, NAK, STALL, DATA1) and request codes (8'h05, 8'h09) SHALL live in the shared usb_defs package, reused by the host-side enumerator.
REQ-024 Setup-packet byte capture, counting and the validity check SHALL be one sub-module, usb_setup_capture. It outputs the 64-bit setup word and a one-cycle valid/invalid strobe.
REQ-025 State SHALL use the codebase's registered-state, combinational next-state/control-word style.

Verification
REQ-026 Set-address flow: SETUP(addr 0, ep 0) + bytes 00 05 01 00 00 00 00 00 + 2 CRC bytes, crc_ok -> ACK. Then IN(addr 0) -> zlp_start; then ACK -> dev_addr=1, and only after APPLY.
REQ-027 Set-config flow at addr 1: bytes 00 09 01 00 ... -> ACK, ZLP, host ACK -> configured=1, config_value=8'h01. Repeat with value 0 -> configured=0.
REQ-028 Malformed setup: 9-byte packet, or 10 bytes with crc_ok=0 -> no hs_start, state IDLE. Unsupported request 80 06 ... -> STALL, no state change.
REQ-029 Status retry and abort:
- NAK token in STATUS_ACK -> new IN -> second zlp_start.
- New SETUP in STATUS_WAIT -> pending SET_ADDRESS discarded and dev_addr unchanged.
REQ-030 bus_rst while configured at addr 1, coincident with a host ACK -> dev_addr=0, configured=0, no APPLY.
REQ-031 rst=0 pulsed in SETUP_DATA -> all outputs zero next cycle, no strobes afterwards.

Source files
------------

// File: rtl/usb_defs.sv
// usb_defs: PID and standard-request codes shared by the device responder and the host-side enumerator.
package usb_defs;

    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_DATA1 = 4'hB;

    localparam logic [7:0] REQ_SET_ADDRESS = 8'h05;
    localparam logic [7:0] REQ_SET_CONFIG  = 8'h09;

    typedef enum logic [2:0] {
        IDLE,
        SETUP_DATA,
        SETUP_HS,
        STATUS_WAIT,
        STATUS_TX,
        STATUS_ACK,
        APPLY
    } enum_state_e;

    // Only standard host-to-device SET_ADDRESS and SET_CONFIGURATION are handled.
    function automatic logic supported(input logic [15:0] s);
        return s[7:0] == 8'h00 && (s[15:8] == REQ_SET_ADDRESS || s[15:8] == REQ_SET_CONFIG);
    endfunction

endpackage

// File: rtl/usb_setup_capture.sv
// usb_setup_capture: captures the 8-byte setup payload, counts bytes (saturating at 15)
// and flags the packet good (8 data + 2 CRC bytes, CRC ok) or bad at end of packet.
module usb_setup_capture (
    input  logic        c_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  rxd_i,
    input  logic        rxdv_i,
    input  logic        rx_eop_i,
    input  logic        rx_crc_ok_i,
    output logic [63:0] setup_o,
    output logic        ok_o,
    output logic        bad_o
);

    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] data_q, data_d;

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && rxdv_i) begin
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            if (!cnt_q[3])
                data_d[{cnt_q[2:0], 3'b000} +: 8] = rxd_i;
        end
    end

    always_ff @(posedge c_i) begin
        if (!rst_i) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign setup_o = data_q;
    assign ok_o    = en_i && rx_eop_i && rx_crc_ok_i && cnt_q == 4'd10;
    assign bad_o   = en_i && rx_eop_i && !ok_o;

endmodule

// File: rtl/usb_dev_enum_resp.sv
// usb_dev_enum_resp: endpoint-0 responder for SET_ADDRESS / SET_CONFIGURATION;
// handshakes the setup stage, sends the status ZLP and applies the request after the host ACK.
module usb_dev_enum_resp
    import usb_defs::*;
(
    input  logic       c_i,
    input  logic       rst_i,
    input  logic       bus_rst_i,
    input  logic       tok_dv_i,
    input  logic [3:0] tok_pid_i,
    input  logic [6:0] tok_addr_i,
    input  logic [3:0] tok_ep_i,
    input  logic [7:0] rxd_i,
    input  logic       rxdv_i,
    input  logic       rx_eop_i,
    input  logic       rx_crc_ok_i,
    input  logic       tx_sie_done_i,
    output logic       hs_start_o,
    output logic [3:0] hs_pid_o,
    output logic       zlp_start_o,
    output logic [6:0] dev_addr_o,
    output logic       configured_o,
    output logic [7:0] config_value_o
);

    enum_state_e state_q, state_d;
    logic        hs_start_q, hs_start_d, zlp_q, zlp_d, clr;
    logic [3:0]  hs_pid_q, hs_pid_d;
    logic [6:0]  dev_addr_q;
    logic [7:0]  config_q;
    logic [63:0] setup;
    logic        ok, bad, match, setup_tok, in_tok, unused_setup;

    usb_setup_capture u_cap (
        .c_i         (c_i),
        .rst_i       (rst_i),
        .clr_i       (clr),
        .en_i        (state_q == SETUP_DATA),
        .rxd_i       (rxd_i),
        .rxdv_i      (rxdv_i),
        .rx_eop_i    (rx_eop_i),
        .rx_crc_ok_i (rx_crc_ok_i),
        .setup_o     (setup),
        .ok_o        (ok),
        .bad_o       (bad)
    );

    assign unused_setup = ^setup[63:24];
    assign match        = tok_dv_i && tok_addr_i == dev_addr_q && tok_ep_i == 4'd0;
    assign setup_tok    = match && tok_pid_i == PID_SETUP;
    assign in_tok       = match && tok_pid_i == PID_IN;

    always_comb begin
        state_d    = state_q;
        hs_start_d = 1'b0;
        hs_pid_d   = hs_pid_q;
        zlp_d      = 1'b0;
        clr        = 1'b0;
        case (state_q)
            IDLE: begin
                hs_start_d = in_tok;
                hs_pid_d   = in_tok ? PID_STALL : hs_pid_q;
            end
            SETUP_DATA: begin
                state_d    = ok ? SETUP_HS : (bad ? IDLE : state_q);
                hs_start_d = ok;
                hs_pid_d   = ok ? (supported(setup[15:0]) ? PID_ACK : PID_STALL) : hs_pid_q;
            end
            SETUP_HS:    state_d = tx_sie_done_i ? ((hs_pid_q == PID_ACK) ? STATUS_WAIT : IDLE) : state_q;
            STATUS_WAIT: begin
                state_d = in_tok ? STATUS_TX : state_q;
                zlp_d   = in_tok;
            end
            STATUS_TX:   state_d = tx_sie_done_i ? STATUS_ACK : state_q;
            STATUS_ACK:  state_d = tok_dv_i ? ((tok_pid_i == PID_ACK) ? APPLY : STATUS_WAIT) : state_q;
            default:     state_d = IDLE;
        endcase
        // A fresh SETUP restarts the transfer except while a transmission is in flight.
        if (setup_tok && state_q != SETUP_HS && state_q != STATUS_TX) begin
            state_d = SETUP_DATA;
            clr     = 1'b1;
        end
    end

    always_ff @(posedge c_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            hs_start_q <= 1'b0;
            hs_pid_q   <= '0;
            zlp_q      <= 1'b0;
            dev_addr_q <= '0;
            config_q   <= '0;
        end else if (bus_rst_i) begin
            state_q    <= IDLE;
            hs_start_q <= 1'b0;
            zlp_q      <= 1'b0;
            dev_addr_q <= '0;
            config_q   <= '0;
        end else begin
            state_q    <= state_d;
            hs_start_q <= hs_start_d;
            hs_pid_q   <= hs_pid_d;
            zlp_q      <= zlp_d;
            if (state_q == APPLY && setup[15:8] == REQ_SET_ADDRESS)
                dev_addr_q <= setup[22:16];
            if (state_q == APPLY && setup[15:8] == REQ_SET_CONFIG)
                config_q <= setup[23:16];
        end
    end

    assign hs_start_o     = hs_start_q;
    assign hs_pid_o       = hs_pid_q;
    assign zlp_start_o    = zlp_q;
    assign dev_addr_o     = dev_addr_q;
    assign config_value_o = config_q;
    assign configured_o   = |config_q;

endmodule

// File: tb/tb_usb_dev_enum_resp.sv
// tb_usb_dev_enum_resp: table-driven control transfers with a strobe scoreboard checking kind, PID and 1-cycle latency.
module tb_usb_dev_enum_resp;

    localparam logic [3:0] SETUP = 4'hD, IN = 4'h9, ACK = 4'h2, NAK = 4'hA, STALL = 4'hE;

    logic       c = 0, rst = 0, bus_rst = 0, tok_dv = 0, rxdv = 0, rx_eop = 0, rx_crc_ok = 0, tx_sie_done = 0;
    logic [3:0] tok_pid = 0, tok_ep = 0;
    logic [6:0] tok_addr = 0;
    logic [7:0] rxd = 0;
    logic       hs_start, zlp_start, configured;
    logic [3:0] hs_pid;
    logic [6:0] dev_addr;
    logic [7:0] config_value;
    int         errors = 0, checks = 0, cyc = 0;
    logic [6:0] cur_addr;

    usb_dev_enum_resp dut (
        .c_i(c), .rst_i(rst), .bus_rst_i(bus_rst), .tok_dv_i(tok_dv), .tok_pid_i(tok_pid),
        .tok_addr_i(tok_addr), .tok_ep_i(tok_ep), .rxd_i(rxd), .rxdv_i(rxdv), .rx_eop_i(rx_eop),
        .rx_crc_ok_i(rx_crc_ok), .tx_sie_done_i(tx_sie_done), .hs_start_o(hs_start), .hs_pid_o(hs_pid),
        .zlp_start_o(zlp_start), .dev_addr_o(dev_addr), .configured_o(configured), .config_value_o(config_value)
    );

    always #5 c = ~c;
    always @(posedge c) cyc <= cyc + 1;

    // kind: 1 = handshake, 2 = ZLP
    typedef struct { int kind; logic [3:0] pid; int at; } exp_t;
    exp_t q[$];

    typedef struct { logic [7:0] b0, b1, b2; int n; bit crc; int kind; logic [3:0] pid; logic [6:0] addr; logic [7:0] cfg; } vec_t;
    vec_t v[11];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge c) begin
        exp_t e;
        if (hs_start || zlp_start) begin
            check("strobe_overlap", {31'd0, hs_start & zlp_start}, 0);
            if (q.size() == 0 || q[0].at != cyc) begin
                errors++;
                checks++;
                $display("FAIL unexpected_strobe: hs=%0b zlp=%0b pid=%0h at cycle %0d, none expected", hs_start, zlp_start, hs_pid, cyc);
            end else begin
                e = q.pop_front();
                check("strobe_kind", hs_start ? 1 : 2, e.kind);
                if (hs_start) check("hs_pid", {28'd0, hs_pid}, {28'd0, e.pid});
            end
        end
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            errors++;
            checks++;
            $display("FAIL missing_strobe: kind %0d pid %0h due cycle %0d, strobe absent", e.kind, e.pid, e.at);
        end
    end

    task automatic tick();
        @(negedge c);
    endtask

    task automatic expect_strobe(int kind, logic [3:0] pid);
        if (kind != 0) q.push_back('{kind, pid, cyc + 1});
    endtask

    task automatic tok(logic [3:0] pid, logic [6:0] addr, logic [3:0] ep, int kind, logic [3:0] epid);
        expect_strobe(kind, epid);
        tok_dv = 1; tok_pid = pid; tok_addr = addr; tok_ep = ep;
        tick();
        tok_dv = 0;
    endtask

    task automatic done();
        tx_sie_done = 1;
        tick();
        tx_sie_done = 0;
    endtask

    task automatic send_bytes(logic [7:0] b0, b1, b2, int from, int to);
        for (int i = from; i < to; i++) begin
            rxdv = 1;
            rxd = (i == 0) ? b0 : (i == 1) ? b1 : (i == 2) ? b2 : (i < 8) ? 8'h00 : 8'hA5;
            tick();
        end
        rxdv = 0;
    endtask

    task automatic eop(bit crc, int kind, logic [3:0] epid);
        expect_strobe(kind, epid);
        rx_eop = 1; rx_crc_ok = crc;
        tick();
        rx_eop = 0; rx_crc_ok = 0;
    endtask

    task automatic send_setup(logic [6:0] addr, logic [7:0] b0, b1, b2, int n, bit crc, int kind, logic [3:0] epid);
        tok(SETUP, addr, 0, 0, 0);
        send_bytes(b0, b1, b2, 0, n);
        eop(crc, kind, epid);
    endtask

    // Full ACKed request: setup, ZLP status, host ACK; dev_addr must hold until APPLY completes.
    task automatic xfer(logic [6:0] addr, logic [7:0] b1, b2);
        send_setup(addr, 8'h00, b1, b2, 10, 1, 1, ACK);
        done();
        tok(IN, addr, 0, 2, 0);
        check("addr_before_apply", {25'd0, dev_addr}, {25'd0, addr});
        done();
        tok(ACK, 7'h55, 4'h3, 0, 0);
        check("addr_in_apply", {25'd0, dev_addr}, {25'd0, addr});
        tick();
    endtask

    task automatic check_regs(string tag, logic [6:0] a, logic [7:0] cfg);
        check({tag, "_addr"}, {25'd0, dev_addr}, {25'd0, a});
        check({tag, "_cfg"}, {24'd0, config_value}, {24'd0, cfg});
        check({tag, "_configured"}, {31'd0, configured}, {31'd0, cfg != 0});
    endtask

    initial begin
        v[0]  = '{8'h00, 8'h05, 8'h01, 10, 1, 1, ACK,   7'h01, 8'h00};
        v[1]  = '{8'h00, 8'h09, 8'h01, 10, 1, 1, ACK,   7'h01, 8'h01};
        v[2]  = '{8'h00, 8'h09, 8'h00, 10, 1, 1, ACK,   7'h01, 8'h00};
        v[3]  = '{8'h00, 8'h09, 8'h07, 10, 1, 1, ACK,   7'h01, 8'h07};
        v[4]  = '{8'h00, 8'h05, 8'h22,  9, 1, 0, 4'h0,  7'h01, 8'h07};
        v[5]  = '{8'h00, 8'h05, 8'h22, 10, 0, 0, 4'h0,  7'h01, 8'h07};
        v[6]  = '{8'h00, 8'h05, 8'h22, 11, 1, 0, 4'h0,  7'h01, 8'h07};
        v[7]  = '{8'h00, 8'h05, 8'h22, 26, 1, 0, 4'h0,  7'h01, 8'h07};
        v[8]  = '{8'h80, 8'h06, 8'h01, 10, 1, 1, STALL, 7'h01, 8'h07};
        v[9]  = '{8'h00, 8'h05, 8'hFF, 10, 1, 1, ACK,   7'h7F, 8'h07};
        v[10] = '{8'h00, 8'h05, 8'h01, 10, 1, 1, ACK,   7'h01, 8'h07};

        repeat (2) tick();
        check("rst_hs_start", {31'd0, hs_start}, 0);
        check("rst_zlp_start", {31'd0, zlp_start}, 0);
        check("rst_hs_pid", {28'd0, hs_pid}, 0);
        check_regs("rst", 7'h00, 8'h00);
        rst = 1;
        tick();
        cur_addr = 7'h00;

        for (int i = 0; i < 11; i++) begin
            if (v[i].kind == 1 && v[i].pid == ACK) begin
                xfer(cur_addr, v[i].b1, v[i].b2);
            end else begin
                send_setup(cur_addr, v[i].b0, v[i].b1, v[i].b2, v[i].n, v[i].crc, v[i].kind, v[i].pid);
                if (v[i].kind == 1) done();
                else tick();
                tok(IN, cur_addr, 0, 1, STALL);
            end
            check_regs($sformatf("vec%0d", i), v[i].addr, v[i].cfg);
            cur_addr = v[i].addr;
        end

        // Status retry: NAK in STATUS_ACK, second IN gets a second ZLP; wrong-endpoint IN ignored.
        send_setup(7'h01, 8'h00, 8'h09, 8'h03, 10, 1, 1, ACK);
        done();
        tok(IN, 7'h01, 4'h1, 0, 0);
        tok(IN, 7'h01, 0, 2, 0);
        done();
        tok(NAK, 7'h01, 0, 0, 0);
        tok(IN, 7'h01, 0, 2, 0);
        done();
        tok(ACK, 7'h00, 0, 0, 0);
        tick();
        check_regs("retry", 7'h01, 8'h03);

        // Abort: SETUP in STATUS_WAIT discards the pending SET_ADDRESS.
        send_setup(7'h01, 8'h00, 8'h05, 8'h33, 10, 1, 1, ACK);
        done();
        send_setup(7'h01, 8'h00, 8'h09, 8'h00, 9, 1, 0, 0);
        tick();
        check_regs("abort", 7'h01, 8'h03);
        tok(IN, 7'h01, 0, 1, STALL);
        tok(IN, 7'h02, 0, 0, 0);
        tick();

        // Reset mid SETUP_DATA: everything cleared, rest of the packet produces no strobe.
        tok(SETUP, 7'h01, 0, 0, 0);
        send_bytes(8'h00, 8'h05, 8'h44, 0, 4);
        rst = 0;
        tick();
        check("midrst_hs_start", {31'd0, hs_start}, 0);
        check("midrst_zlp_start", {31'd0, zlp_start}, 0);
        check("midrst_hs_pid", {28'd0, hs_pid}, 0);
        check_regs("midrst", 7'h00, 8'h00);
        rst = 1;
        send_bytes(8'h00, 8'h05, 8'h44, 4, 10);
        eop(1, 0, 0);
        done();
        repeat (2) tick();
        check_regs("postrst", 7'h00, 8'h00);

        // bus_rst coincident with the host ACK: registers clear and APPLY never happens.
        xfer(7'h00, 8'h05, 8'h01);
        xfer(7'h01, 8'h09, 8'h05);
        check_regs("pre_busrst", 7'h01, 8'h05);
        send_setup(7'h01, 8'h00, 8'h05, 8'h09, 10, 1, 1, ACK);
        done();
        tok(IN, 7'h01, 0, 2, 0);
        done();
        bus_rst = 1;
        tok(ACK, 7'h01, 0, 0, 0);
        bus_rst = 0;
        check_regs("busrst", 7'h00, 8'h00);
        repeat (2) tick();
        check_regs("busrst_late", 7'h00, 8'h00);
        tok(IN, 7'h00, 0, 1, STALL);

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
